// File: rtl/softshell_pkg.sv
// softshell_pkg
//   Shared definitions for the Softshell bus fabric and its neighbours:
//   fabric FSM state encodings, the Softshell slave address map and the
//   default watchdog limit.
//   Ports: none (package).
package softshell_pkg;

  typedef enum logic [1:0] {
    FAB_IDLE = 2'd0,
    FAB_BUSY = 2'd1,
    FAB_ERR  = 2'd2
  } fab_state_e;

  // Softshell address map (base / mask)
  localparam logic [31:0] RAM_ADDR       = 32'h3000_0000;
  localparam logic [31:0] RAM_MASK       = 32'hfff0_0000;
  localparam logic [31:0] FLASH_ADDR     = 32'h3040_0000;
  localparam logic [31:0] FLASH_MASK     = 32'hfff0_0000;
  localparam logic [31:0] FLASH_CFG_ADDR = 32'h3080_0000;
  localparam logic [31:0] FLASH_CFG_MASK = 32'hffff_0000;
  localparam logic [31:0] UART0_ADDR     = 32'h3081_0000;
  localparam logic [31:0] UART0_MASK     = 32'hffff_0000;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/softshell_rr_arbiter.sv
// softshell_rr_arbiter
//   Combinational round-robin arbiter. Searches upward from the bit above
//   the previous winner, wrapping around to bit 0.
//   Ports:
//     req  in  N  request vector
//     last in  N  one-hot previous winner
//     gnt  out N  one-hot winner (0 when no request)
module softshell_rr_arbiter
  import softshell_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] gnt
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] upper_s;
  logic [N-1:0] req_hi_s;
  logic [N-1:0] pick_hi_s;
  logic [N-1:0] pick_all_s;

  // Prefer the lowest requester strictly above last, else wrap to the lowest overall
  always_comb begin
    upper_s    = ~(last | (last - ONE));
    req_hi_s   = req & upper_s;
    pick_hi_s  = req_hi_s & (~req_hi_s + ONE);
    pick_all_s = req & (~req + ONE);
    if (|req_hi_s) begin
      gnt = pick_hi_s;
    end else begin
      gnt = pick_all_s;
    end
  end

endmodule

// File: rtl/softshell_bus_fabric.sv
// softshell_bus_fabric
//   Wishbone shared-bus fabric: NUM_MASTERS masters arbitrated round-robin
//   onto one bus, decoded to NUM_SLAVES slaves by base/mask. Decode misses
//   return a one-cycle err; an optional watchdog errors out hung transfers.
//   Optional feature macro: SOFTSHELL_FABRIC_TIMEOUT_EN (watchdog + timeout_o).
//   Ports:
//     wb_clk_i, reset_in (async, active-high)
//     m_cyc_i/m_stb_i/m_we_i/m_adr_i/m_dat_i/m_sel_i  master requests (flattened)
//     m_dat_o, m_ack_o, m_err_o                       master responses
//     s_cyc_o/s_stb_o (per slave), s_we_o/s_adr_o/s_dat_o/s_sel_o (shared)
//     s_dat_i, s_ack_i                                slave responses
//     gnt_o      one-hot current grant, timeout_o  watchdog error pulse
module softshell_bus_fabric
  import softshell_pkg::*;
#(
  parameter int NUM_MASTERS    = 5,
  parameter int NUM_SLAVES     = 4,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_ADDR = {NUM_SLAVES{RAM_ADDR}},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {NUM_SLAVES{RAM_MASK}},
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                            wb_clk_i,
  input  logic                            reset_in,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
  output logic [DATA_W-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [NUM_SLAVES-1:0]           s_cyc_o,
  output logic [NUM_SLAVES-1:0]           s_stb_o,
  output logic                            s_we_o,
  output logic [ADDR_W-1:0]               s_adr_o,
  output logic [DATA_W-1:0]               s_dat_o,
  output logic [DATA_W/8-1:0]             s_sel_o,
  input  logic [NUM_SLAVES*DATA_W-1:0]    s_dat_i,
  input  logic [NUM_SLAVES-1:0]           s_ack_i,
  output logic [NUM_MASTERS-1:0]          gnt_o,
  output logic                            timeout_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [NUM_MASTERS-1:0] LAST_RESET = {1'b1, {(NUM_MASTERS-1){1'b0}}};

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("softshell_bus_fabric: TIMEOUT_CYCLES must be 2..255");
  end

  fab_state_e               state_r, state_next_s;
  logic [NUM_MASTERS-1:0]   gnt_r, gnt_next_s, last_r, last_next_s, arb_gnt_s;
  logic                     cyc_s, stb_s, we_s;
  logic [ADDR_W-1:0]        adr_s;
  logic [DATA_W-1:0]        wdat_s, rdat_s;
  logic [SEL_W-1:0]         sel_s;
  logic [NUM_SLAVES-1:0]    hit_s, slv_s;
  logic                     any_hit_s, busy_s, ack_s, expire_s;

  softshell_rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .req  (m_cyc_i),
    .last (last_r),
    .gnt  (arb_gnt_s)
  );

  // One-hot AND-OR mux of the granted master's request fields
  always_comb begin
    cyc_s  = |(m_cyc_i & gnt_r);
    stb_s  = |(m_stb_i & gnt_r);
    we_s   = |(m_we_i & gnt_r);
    adr_s  = '0;
    wdat_s = '0;
    sel_s  = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      adr_s  = adr_s  | (m_adr_i[m*ADDR_W +: ADDR_W] & {ADDR_W{gnt_r[m]}});
      wdat_s = wdat_s | (m_dat_i[m*DATA_W +: DATA_W] & {DATA_W{gnt_r[m]}});
      sel_s  = sel_s  | (m_sel_i[m*SEL_W +: SEL_W]   & {SEL_W{gnt_r[m]}});
    end
  end

  // Address decode; overlapping windows resolve to the lowest slave index
  always_comb begin
    hit_s  = '0;
    rdat_s = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      hit_s[s] = ((adr_s & SLAVE_MASK[s*ADDR_W +: ADDR_W]) == SLAVE_ADDR[s*ADDR_W +: ADDR_W]);
    end
    slv_s     = hit_s & (~hit_s + NUM_SLAVES'(1));
    any_hit_s = |hit_s;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      rdat_s = rdat_s | (s_dat_i[s*DATA_W +: DATA_W] & {DATA_W{slv_s[s]}});
    end
  end

  // Bus outputs: slave selects only while BUSY, ack passes straight through
  always_comb begin
    busy_s  = (state_r == FAB_BUSY) && cyc_s;
    s_cyc_o = slv_s & {NUM_SLAVES{busy_s}};
    s_stb_o = slv_s & {NUM_SLAVES{busy_s && stb_s}};
    s_we_o  = we_s;
    s_adr_o = adr_s;
    s_dat_o = wdat_s;
    s_sel_o = sel_s;
    ack_s   = busy_s && (|(s_ack_i & slv_s));
    m_ack_o = gnt_r & {NUM_MASTERS{ack_s}};
    m_err_o = gnt_r & {NUM_MASTERS{state_r == FAB_ERR}};
    m_dat_o = rdat_s;
    gnt_o   = gnt_r;
  end

`ifdef SOFTSHELL_FABRIC_TIMEOUT_EN
  logic [7:0] wd_cnt_r, wd_cnt_next_s;
  logic       wd_count_s;
  logic       timeout_r;

  // Watchdog: counts stalled strobe cycles; an ack in the expiry cycle wins
  always_comb begin
    wd_count_s = busy_s && stb_s && any_hit_s && !ack_s;
    expire_s   = wd_count_s && (wd_cnt_r == 8'(TIMEOUT_CYCLES - 1));
    if (wd_count_s && !expire_s) begin
      wd_cnt_next_s = wd_cnt_r + 8'd1;
    end else begin
      wd_cnt_next_s = 8'd0;
    end
  end

  // Watchdog counter and timeout pulse registers
  always_ff @(posedge wb_clk_i or posedge reset_in) begin
    if (reset_in) begin
      wd_cnt_r  <= 8'd0;
      timeout_r <= 1'b0;
    end else begin
      wd_cnt_r  <= wd_cnt_next_s;
      timeout_r <= expire_s;
    end
  end

  assign timeout_o = timeout_r;
`else
  assign expire_s  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Fabric FSM next state; the grant is held until the owner drops cyc
  always_comb begin
    state_next_s = state_r;
    gnt_next_s   = gnt_r;
    last_next_s  = last_r;
    case (state_r)
      FAB_IDLE: begin
        if (|m_cyc_i) begin
          state_next_s = FAB_BUSY;
          gnt_next_s   = arb_gnt_s;
          last_next_s  = arb_gnt_s;
        end else begin
          state_next_s = FAB_IDLE;
        end
      end
      FAB_BUSY: begin
        if (!cyc_s) begin
          state_next_s = FAB_IDLE;
          gnt_next_s   = '0;
        end else if (stb_s && !any_hit_s) begin
          state_next_s = FAB_ERR;
        end else if (expire_s) begin
          state_next_s = FAB_ERR;
        end else begin
          state_next_s = FAB_BUSY;
        end
      end
      FAB_ERR: begin
        state_next_s = FAB_BUSY;
      end
      default: begin
        state_next_s = FAB_IDLE;
        gnt_next_s   = '0;
      end
    endcase
  end

  // Fabric state, grant and round-robin pointer registers
  always_ff @(posedge wb_clk_i or posedge reset_in) begin
    if (reset_in) begin
      state_r <= FAB_IDLE;
      gnt_r   <= '0;
      last_r  <= LAST_RESET;
    end else begin
      state_r <= state_next_s;
      gnt_r   <= gnt_next_s;
      last_r  <= last_next_s;
    end
  end

endmodule

// File: tb/tb_softshell_bus_fabric.sv
// tb_softshell_bus_fabric
//   Directed self-checking bench for softshell_bus_fabric. Slaves:
//   0 RAM, 1 UART0, 2 flash, 3 flash cfg. Watchdog limit 16; watchdog
//   checks follow SOFTSHELL_FABRIC_TIMEOUT_EN.
module tb_softshell_bus_fabric;

  logic          wb_clk_i = 1'b0;
  logic          reset_in = 1'b1;
  logic [4:0]    m_cyc_i  = '0;
  logic [4:0]    m_stb_i  = '0;
  logic [4:0]    m_we_i   = '0;
  logic [159:0]  m_adr_i  = '0;
  logic [159:0]  m_dat_i  = '0;
  logic [19:0]   m_sel_i  = '0;
  logic [31:0]   m_dat_o;
  logic [4:0]    m_ack_o, m_err_o;
  logic [3:0]    s_cyc_o, s_stb_o;
  logic          s_we_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic [3:0]    s_sel_o;
  logic [127:0]  s_dat_i  = '0;
  logic [3:0]    s_ack_i  = '0;
  logic [4:0]    gnt_o;
  logic          timeout_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] expg;

  softshell_bus_fabric #(
    .NUM_MASTERS(5), .NUM_SLAVES(4), .DATA_W(32), .ADDR_W(32),
    .SLAVE_ADDR({32'h3080_0000, 32'h3040_0000, 32'h3081_0000, 32'h3000_0000}),
    .SLAVE_MASK({32'hffff_0000, 32'hfff0_0000, 32'hffff_0000, 32'hfff0_0000}),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i(wb_clk_i), .reset_in(reset_in),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic set_master(input int m, input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat);
    m_cyc_i[m]          = cyc;
    m_stb_i[m]          = stb;
    m_we_i[m]           = we;
    m_adr_i[m*32 +: 32] = adr;
    m_dat_i[m*32 +: 32] = dat;
    m_sel_i[m*4 +: 4]   = 4'hf;
  endtask

  task automatic slave_ack(input int s, input logic ack, input logic [31:0] dat);
    s_ack_i[s]          = ack;
    s_dat_i[s*32 +: 32] = dat;
  endtask

  task automatic release_all();
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = '0;
    s_ack_i = '0;
    step();
    step();
  endtask

  initial begin
    // ---- reset state ----
    step();
    step();
    check("rst_gnt",     32'(gnt_o),     32'h0);
    check("rst_s_cyc",   32'(s_cyc_o),   32'h0);
    check("rst_ack",     32'(m_ack_o),   32'h0);
    check("rst_err",     32'(m_err_o),   32'h0);
    check("rst_timeout", 32'(timeout_o), 32'h0);

    // ---- masters 0 and 2 request together in cycle 0 ----
    reset_in = 1'b0;
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'h0);
    set_master(2, 1'b1, 1'b1, 1'b0, 32'h3040_0000, 32'h0);
    #1;
    check("c0_gnt_idle", 32'(gnt_o), 32'h0);
    step();
    check("e1_gnt_m0",   32'(gnt_o),   32'h01);
    check("e1_s_stb",    32'(s_stb_o), 32'h1);
    check("e1_s_adr",    s_adr_o,      32'h3000_0010);
    slave_ack(0, 1'b1, 32'h1234_5678);
    #1;
    check("m0_ack",      32'(m_ack_o), 32'h01);
    check("m0_rdata",    m_dat_o,      32'h1234_5678);
    step();
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    slave_ack(0, 1'b0, 32'h0);
    #1;
    check("rel_gnt_held", 32'(gnt_o),   32'h01);
    check("rel_s_cyc",    32'(s_cyc_o), 32'h0);
    step();
    check("dead_cycle",   32'(gnt_o),   32'h0);
    step();
    check("gnt_m2",       32'(gnt_o),   32'h04);
    check("m2_s_stb",     32'(s_stb_o), 32'h4);
    slave_ack(2, 1'b1, 32'h0);
    #1;
    check("m2_ack",       32'(m_ack_o), 32'h04);
    release_all();

    // ---- round robin with all five masters ----
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    for (int m = 0; m < 5; m++) set_master(m, 1'b1, 1'b1, 1'b0, 32'h3000_0000 + 32'(m * 4), 32'h0);
    step();
    for (int i = 0; i < 6; i++) begin
      expg = 5'(1 << (i % 5));
      check("rr_gnt", 32'(gnt_o), 32'(expg));
      slave_ack(0, 1'b1, 32'h100 + 32'(i));
      #1;
      check("rr_ack", 32'(m_ack_o), 32'(expg));
      step();
      set_master(i % 5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      slave_ack(0, 1'b0, 32'h0);
      step();
      set_master(i % 5, 1'b1, 1'b1, 1'b0, 32'h3000_0000 + 32'((i % 5) * 4), 32'h0);
      step();
    end
    release_all();

    // ---- master 1 reads UART, ack after 3 cycles ----
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h3081_0004, 32'h0);
    step();
    check("uart_gnt",   32'(gnt_o),   32'h02);
    check("uart_s_stb", 32'(s_stb_o), 32'h2);
    check("uart_wait1", 32'(m_ack_o), 32'h0);
    step();
    check("uart_wait2", 32'(m_ack_o), 32'h0);
    step();
    slave_ack(1, 1'b1, 32'h0000_00a5);
    #1;
    check("uart_ack",   32'(m_ack_o), 32'h02);
    check("uart_data",  m_dat_o,      32'h0000_00a5);
    check("uart_noerr", 32'(m_err_o), 32'h0);
    release_all();

    // ---- master 3 decode miss ----
    set_master(3, 1'b1, 1'b1, 1'b0, 32'h3500_0000, 32'h0);
    step();
    check("miss_gnt",   32'(gnt_o),   32'h08);
    check("miss_s_stb", 32'(s_stb_o), 32'h0);
    check("miss_noerr", 32'(m_err_o), 32'h0);
    step();
    check("miss_err",   32'(m_err_o), 32'h08);
    set_master(3, 1'b1, 1'b0, 1'b0, 32'h3500_0000, 32'h0);
    step();
    check("miss_err_1cyc", 32'(m_err_o), 32'h0);
    release_all();

    // ---- watchdog: RAM never acks ----
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h3000_0020, 32'h0);
    step();
    check("wd_s_stb", 32'(s_stb_o), 32'h1);
    for (int c = 0; c < 16; c++) begin
      #1;
      check("wd_no_err_early", 32'(m_err_o), 32'h0);
      check("wd_no_to_early",  32'(timeout_o), 32'h0);
      step();
    end
    #1;
`ifdef SOFTSHELL_FABRIC_TIMEOUT_EN
    check("wd_err",     32'(m_err_o),   32'h01);
    check("wd_timeout", 32'(timeout_o), 32'h1);
`else
    check("wd_off_err",     32'(m_err_o),   32'h0);
    check("wd_off_timeout", 32'(timeout_o), 32'h0);
`endif
    release_all();

    // ---- watchdog: ack in the last allowed cycle ----
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h3000_0020, 32'h0);
    step();
    for (int c = 0; c < 15; c++) step();
    slave_ack(0, 1'b1, 32'h0);
    #1;
    check("wd_late_ack", 32'(m_ack_o), 32'h01);
    step();
    slave_ack(0, 1'b0, 32'h0);
    #1;
    check("wd_late_noerr", 32'(m_err_o),   32'h0);
    check("wd_late_noto",  32'(timeout_o), 32'h0);
    release_all();

    // ---- reset during a master 2 flash write ----
    set_master(2, 1'b1, 1'b1, 1'b1, 32'h3040_0008, 32'hdead_beef);
    step();
    check("wr_gnt",   32'(gnt_o),   32'h04);
    check("wr_s_cyc", 32'(s_cyc_o), 32'h4);
    check("wr_we",    32'(s_we_o),  32'h1);
    check("wr_data",  s_dat_o,      32'hdead_beef);
    check("wr_sel",   32'(s_sel_o), 32'hf);
    step();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0);
    reset_in = 1'b1;
    slave_ack(2, 1'b1, 32'h0);
    #1;
    check("mid_rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("mid_rst_s_stb", 32'(s_stb_o), 32'h0);
    check("mid_rst_gnt",   32'(gnt_o),   32'h0);
    check("mid_rst_ack",   32'(m_ack_o), 32'h0);
    step();
    reset_in = 1'b0;
    slave_ack(2, 1'b0, 32'h0);
    #1;
    check("post_rst_idle", 32'(gnt_o), 32'h0);
    step();
    check("post_rst_m0",   32'(gnt_o), 32'h01);
    release_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/softshell_bus_fabric.md
# softshell_bus_fabric

Parametrised Wishbone shared-bus fabric for Softshell: N masters (Caravel port plus CPU cores) arbitrated round-robin onto one bus, decoded to M slaves by base/mask. It generalises the fixed 5-master, 4-slave arbiter/mux pair, and adds three behaviours: error response on address-decode miss, a per-transfer watchdog timeout, and exported grant status for the logic analyzer.

## Interface
- NUM_MASTERS, 5, number of masters; index 0 is the Caravel port
- NUM_SLAVES, 4, number of slaves
- DATA_W, 32, data width; select width is DATA_W/8
- ADDR_W, 32, address width
- SLAVE_ADDR, {NUM_SLAVES{32'h3000_0000}}, flattened per-slave base addresses; slave s at [s*ADDR_W +: ADDR_W]
- SLAVE_MASK, {NUM_SLAVES{32'hfff0_0000}}, flattened per-slave masks, same layout
- TIMEOUT_CYCLES, 255, watchdog limit; 8-bit counter, legal range 2..255
- wb_clk_i  in  1  clock
- reset_in  in  1  asynchronous, active-high reset
- m_cyc_i, m_stb_i, m_we_i  in  NUM_MASTERS  per-master Wishbone controls
- m_adr_i  in  NUM_MASTERS*ADDR_W  flattened master addresses
- m_dat_i  in  NUM_MASTERS*DATA_W  flattened master write data
- m_sel_i  in  NUM_MASTERS*DATA_W/8  flattened master byte selects
- m_dat_o  out  DATA_W  read data; shared, qualify with ack
- m_ack_o, m_err_o  out  NUM_MASTERS  per-master responses
- s_cyc_o, s_stb_o  out  NUM_SLAVES  per-slave selects
- s_we_o, s_adr_o, s_dat_o, s_sel_o  out  1/ADDR_W/DATA_W/DATA_W/8  shared request fields
- s_dat_i  in  NUM_SLAVES*DATA_W  flattened slave read data
- s_ack_i  in  NUM_SLAVES  slave acks
- gnt_o  out  NUM_MASTERS  one-hot current grant; 0 when idle
- timeout_o  out  1  one-cycle pulse when a watchdog error fires

## Operation
- States: IDLE, BUSY, ERR.
- IDLE:
  - If any m_cyc_i is high, grant the first requester found searching upward, with wrap-around, from last_gnt+1.
  - Register the grant and last_gnt; move to BUSY.
- BUSY:
  - Granted master's adr/dat/sel/we drive the shared s_* fields.
  - Decode: slave s matches when (adr & MASK[s]) == ADDR[s]. If several slaves match, the lowest index wins.
  - s_cyc_o[s] = granted cyc and match; s_stb_o[s] = granted stb and match.
  - m_ack_o[g] = s_ack_i[s] combinationally; m_dat_o = s_dat_i[s].
  - Granted cyc low: go to IDLE and clear the grant.
  - Stb high with no decode match: go to ERR.
  - Watchdog expiry: go to ERR and pulse timeout_o.
- ERR:
  - m_err_o[g] high for exactly one cycle; all s_cyc_o/s_stb_o low.
  - Then return to BUSY; grant is retained.
- Watchdog:
  - Counts cycles with granted stb high, a matching slave, and no ack.
  - Cleared on ack, on leaving BUSY, or when stb is low.
  - Expiry is count == TIMEOUT_CYCLES-1 with no ack that cycle.
- Grant is held for the entire cyc assertion (block/RMW transfers are never split).
- Ungranted masters see ack/err = 0.

## Timing
- Reset (async, immediate):
  - State IDLE; gnt_o = 0; last_gnt = NUM_MASTERS-1, so master 0 wins first.
  - All s_cyc_o/s_stb_o/m_ack_o/m_err_o/timeout_o = 0; counter = 0.
- Reset asserted mid-transfer: slave strobes drop in the same cycle; the transfer is abandoned and no ack is forwarded.
- Arbitration latency: cyc rises in cycle 0 → grant at edge 1 → slave stb visible in cycle 1.
- Ack path: combinational, zero added latency.
- Release: cyc falls in cycle k → IDLE in k+1 → new grant at edge k+2. There is one dead cycle between owners.
- Decode miss: stb in cycle n → err in cycle n+1.
- Ack and watchdog expiry in the same cycle: ack wins; no error, no timeout pulse.
- Requests arriving during BUSY wait; fairness: every requester is granted within NUM_MASTERS-1 other grants.

## Configuration
- SOFTSHELL_FABRIC_TIMEOUT_EN:
  - Defined: watchdog counter and timeout_o present as described.
  - Undefined: no counter; timeout_o tied 0; a hung slave stalls the bus until reset_in.
- Decode-miss error is always present, independent of the macro.

## Structure
- Shared package softshell_pkg holds:
  - State encodings FAB_IDLE=2'd0, FAB_BUSY=2'd1, FAB_ERR=2'd2.
  - Softshell address map constants (RAM 3000_0000/fff0_0000, flash 3040_0000/fff0_0000, flash cfg 3080_0000/ffff_0000, UART0 3081_0000/ffff_0000).
  - Default TIMEOUT_CYCLES.
- Sub-module softshell_rr_arbiter, parameter N:
  - Inputs req[N-1:0] and last[N-1:0] (one-hot).
  - Output gnt[N-1:0] (one-hot, combinational).
  - Instantiated once; reusable elsewhere in the design.

## Test plan
- Reset release, masters 0 and 2 request together in cycle 0 → gnt_o=5'b00001 at edge 1. After master 0 drops cyc, gnt_o=5'b00100 two cycles later.
- All 5 masters hold cyc continuously, each doing a single RAM access → grant order 0,1,2,3,4,0, with no master granted twice before all others.
- Master 1 reads 3081_0004, UART acks after 3 cycles with 32'hA5 → m_ack_o[1] in the same cycle as s_ack_i[1], m_dat_o=32'hA5, no err.
- Master 3 strobes 3500_0000 (no slave) → no s_stb_o; m_err_o[3] pulses exactly one cycle later.
- TIMEOUT_EN, TIMEOUT_CYCLES=16, RAM never acks → m_err_o and timeout_o pulse 16 cycles after stb rises. With the ack at cycle 15 instead, no error.
- reset_in asserted while master 2 is mid-write to flash → s_cyc_o=0 immediately, gnt_o=0; after release, master 0 wins first.
